// File: rtl/regfile_writeback.sv
// Write-back buffer for the register file: queues ALU/load results, sign-extends
// load-byte data, commits one entry per clock and forwards still-pending values.
module regfile_writeback #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wb_valid,
    output logic                   wb_ready,
    input  logic [4:0]             wb_reg,
    input  logic [31:0]            wb_data,
    input  logic                   wb_byte,
    input  logic                   flush,
    output logic [4:0]             write_reg,
    output logic [31:0]            write_data,
    output logic                   regWrite,
    output logic                   byteOperations,
    input  logic [4:0]             fwd_reg1,
    input  logic [4:0]             fwd_reg2,
    output logic                   fwd_hit1,
    output logic                   fwd_hit2,
    output logic [31:0]            fwd_data1,
    output logic [31:0]            fwd_data2,
    output logic [$clog2(DEPTH):0] pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    r_regs [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic          r_byte [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          r_reg_write;
    logic [4:0]    r_write_reg;
    logic [31:0]   r_write_data;
    logic          r_byte_op;

    logic          w_ready;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_data_fmt;
    logic [32:0]   w_fwd1;
    logic [32:0]   w_fwd2;

    // Register 0 completes the handshake but never occupies a slot.
    assign w_ready    = (r_count != CW'(DEPTH));
    assign w_push     = wb_valid && w_ready && (wb_reg != 5'd0);
    assign w_pop      = (r_count != '0);
    assign w_data_fmt = wb_byte ? {{24{wb_data[7]}}, wb_data[7:0]} : wb_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_byte_op    <= 1'b0;
        end else if (flush) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_reg_write <= 1'b0;
        end else begin
            if (w_pop) begin
                r_reg_write  <= 1'b1;
                r_write_reg  <= r_regs[r_rptr];
                r_write_data <= r_data[r_rptr];
                r_byte_op    <= r_byte[r_rptr];
                r_rptr       <= r_rptr + PW'(1);
            end else begin
                r_reg_write <= 1'b0;
            end
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_regs[r_wptr] <= wb_reg;
            r_data[r_wptr] <= w_data_fmt;
            r_byte[r_wptr] <= wb_byte;
        end
    end

    // Scan oldest to newest so the newest match overwrites; output stage is lowest priority.
    function automatic logic [32:0] lookup(input logic [4:0] q);
        logic          hit;
        logic [31:0]   d;
        logic [PW-1:0] idx;
        hit = 1'b0;
        d   = '0;
        if (r_reg_write && (r_write_reg == q)) begin
            hit = 1'b1;
            d   = r_write_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_rptr + PW'(i);
            if ((CW'(i) < r_count) && (r_regs[idx] == q)) begin
                hit = 1'b1;
                d   = r_data[idx];
            end
        end
        if (q == 5'd0) begin
            hit = 1'b0;
            d   = '0;
        end
        return {hit, d};
    endfunction

    always_comb begin
        w_fwd1 = lookup(fwd_reg1);
        w_fwd2 = lookup(fwd_reg2);
    end

    assign fwd_hit1       = w_fwd1[32];
    assign fwd_data1      = w_fwd1[31:0];
    assign fwd_hit2       = w_fwd2[32];
    assign fwd_data2      = w_fwd2[31:0];
    assign wb_ready       = w_ready;
    assign pending        = r_count;
    assign regWrite       = r_reg_write;
    assign write_reg      = r_write_reg;
    assign write_data     = r_write_data;
    assign byteOperations = r_byte_op;

endmodule
